// File: rtl/img_buffer_ctrl.sv
// Image receive buffer and inference handshake controller: packs host bytes MSB-first, then runs a result/clear/report cycle.
// Optional inference watchdog enabled by defining BNN_TIMEOUT_EN.
module img_buffer_ctrl #(
    parameter int IMG_BITS       = 904,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic                bnn_enable,
    output logic                bnn_clear,
    input  logic [3:0]          result_in,
    input  logic                result_ready,
    output logic [3:0]          res_out,
    output logic                res_valid,
    input  logic                res_ack,
    output logic                res_err
);

    localparam int NBYTES = IMG_BITS / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW     = $clog2(IMG_BITS);

    typedef enum logic [2:0] {RX, INFER, CLEAR, DRAIN, REPORT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_lsb;
    logic          last_byte;

    // Byte k lands in the k-th byte lane counted from the top of img_out.
    assign wr_lsb    = IW'((NBYTES - 1 - int'(cnt)) * 8);
    assign last_byte = (cnt == CW'(NBYTES - 1));

`ifdef BNN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;
    logic          wd_expired;

    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign res_err    = err_q;
`else
    assign res_err = 1'b0;
`endif

    // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RX;
            cnt             <= '0;
            img_out         <= '0;
            res_out         <= '0;
            byte_ready      <= 1'b1;
            img_buffer_full <= 1'b0;
            bnn_enable      <= 1'b0;
            bnn_clear       <= 1'b0;
            res_valid       <= 1'b0;
`ifdef BNN_TIMEOUT_EN
            wd_cnt          <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            case (state)
                RX: begin
                    if (byte_valid && byte_ready) begin
                        img_out[wr_lsb +: 8] <= byte_in;
                        if (last_byte) begin
                            cnt             <= '0;
                            state           <= INFER;
                            byte_ready      <= 1'b0;
                            img_buffer_full <= 1'b1;
                            bnn_enable      <= 1'b1;
`ifdef BNN_TIMEOUT_EN
                            wd_cnt          <= '0;
                            err_q           <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                INFER: begin
                    if (result_ready) begin
                        res_out         <= result_in;
                        state           <= CLEAR;
                        img_buffer_full <= 1'b0;
                        bnn_enable      <= 1'b0;
                        bnn_clear       <= 1'b1;
`ifdef BNN_TIMEOUT_EN
                    end else if (wd_expired) begin
                        res_out         <= 4'hF;
                        err_q           <= 1'b1;
                        state           <= CLEAR;
                        img_buffer_full <= 1'b0;
                        bnn_enable      <= 1'b0;
                        bnn_clear       <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
`endif
                    end
                end
                CLEAR: begin
                    state     <= DRAIN;
                    bnn_clear <= 1'b0;
                end
                DRAIN: begin
                    // Report only once the inference side has dropped its stale result.
                    if (!result_ready) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ack) begin
                        state      <= RX;
                        res_valid  <= 1'b0;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state           <= RX;
                    byte_ready      <= 1'b1;
                    img_buffer_full <= 1'b0;
                    bnn_enable      <= 1'b0;
                    bnn_clear       <= 1'b0;
                    res_valid       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/img_buffer_ctrl.md
IMG_BUFFER_CTRL -- requirements
Module: img_buffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_BITS, default 904, meaning image buffer width (multiple of 8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning watchdog limit (used only with BNN_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port byte_in  input  8  image byte from host link.
REQ-006 SHALL have port byte_valid  input  1  byte_in valid.
REQ-007 SHALL have port byte_ready  output  1  controller accepts byte this cycle.
REQ-008 SHALL have port img_out  output  IMG_BITS  packed image to inference block.
REQ-009 SHALL have port img_buffer_full  output  1  img_out complete and stable.
REQ-010 SHALL have port bnn_enable  output  1  start or hold inference.
REQ-011 SHALL have port bnn_clear  output  1  one-cycle clear of inference-side result.
REQ-012 SHALL have port result_in  input  4  class index from inference block.
REQ-013 SHALL have port result_ready  input  1  result_in valid, held until clear.
REQ-014 SHALL have port res_out  output  4  captured class index to host.
REQ-015 SHALL have port res_valid  output  1  res_out valid, held until res_ack.
REQ-016 SHALL have port res_ack  input  1  host consumed res_out.
REQ-017 SHALL have port res_err  output  1  timeout flag (tied 0 without BNN_TIMEOUT_EN).

Function
REQ-018 SHALL implement FSM states RX, INFER, CLEAR, DRAIN, REPORT.
REQ-019 SHALL drive byte_ready=1 only in RX; transfer occurs when byte_valid && byte_ready.
REQ-020 SHALL pack bytes MSB-first: byte k (k=0..IMG_BITS/8-1) written to img_out[IMG_BITS-1-8k -: 8].
REQ-021 SHALL count accepted bytes with a counter of width clog2(IMG_BITS/8) and, on the last byte (k=112 at default), go to INFER next cycle and reset the counter to 0.
REQ-022 SHALL hold img_out unchanged outside RX.
REQ-023 SHALL drive img_buffer_full=1 and bnn_enable=1 in INFER, 0 in all other states.
REQ-024 SHALL, in INFER with result_ready=1, register result_in into res_out and go to CLEAR.
REQ-025 SHALL drive bnn_clear=1 for exactly the one cycle spent in CLEAR, then go to DRAIN.
REQ-026 SHALL stay in DRAIN until result_ready=0, then go to REPORT; res_valid SHALL NOT be asserted before that.
REQ-027 SHALL drive res_valid=1 throughout REPORT; on res_ack=1 go to RX next cycle; res_ack outside REPORT ignored.
REQ-028 SHALL ignore byte_valid in all states other than RX (no buffering, no overwrite).
REQ-029 SHALL keep res_out stable from capture until the next capture.

Reset
REQ-030 SHALL, on rst=1 at a clock edge (including mid-frame or mid-inference), enter RX, clear counter, img_out=0, res_out=0, res_err=0, and drive byte_ready=1 (RX), img_buffer_full=0, bnn_enable=0, bnn_clear=0, res_valid=0 from the following cycle.
REQ-031 SHALL give rst priority over every other input in the same cycle.

Configuration
REQ-032 SHALL, with macro BNN_TIMEOUT_EN defined, count cycles in INFER; on reaching TIMEOUT_CYCLES without result_ready, set res_out=4'hF and res_err=1, then go to CLEAR.
REQ-033 SHALL clear res_err on entry to INFER and on reset.
REQ-034 SHALL, without BNN_TIMEOUT_EN, contain no watchdog counter, wait in INFER indefinitely, and tie res_err to 0.

Verification
REQ-035 Reset mid-frame: send 50 bytes, assert rst 1 cycle -> counter=0, img_out=0, all control outputs 0 except byte_ready=1; next frame fills from byte 0.
REQ-036 Full frame: 113 bytes 0x00..0x70 with gaps in byte_valid -> img_out[903:896]=0x00, img_out[7:0]=0x70; img_buffer_full=bnn_enable=1 cycle after last byte; byte_ready=0.
REQ-037 Result path: model result_ready=1, result_in=4'd7 after 20 cycles and holds until 1 cycle after bnn_clear -> bnn_clear single-cycle pulse, res_valid rises only after result_ready=0, res_out=7.
REQ-038 Host backpressure: res_ack low 10 cycles with byte_valid=1 -> res_valid held, byte_ready=0, no bytes accepted; res_ack=1 -> RX next cycle.
REQ-039 Timeout (BNN_TIMEOUT_EN, TIMEOUT_CYCLES=16): never assert result_ready -> after 16 INFER cycles res_out=4'hF, res_err=1, bnn_clear pulses; without macro FSM remains in INFER.
REQ-040 Back-to-back frames: two frames with res_ack asserted immediately -> both results reported in order, second frame's first byte lands at img_out[903:896].
